// File: rtl/unsigned_seq_mult_ls.sv
// Sequential unsigned shift-and-add multiplier, MSB-first over the multiplier.
// One multiplier bit per clock; done rises WIDTH edges after the load edge.
module unsigned_seq_mult_ls #(
    parameter int WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] out;
    logic [CW-1:0]      counter;

    logic [IW-1:0]      idx;
    logic [2*WIDTH-1:0] addend;

    // Bit under the scan; only meaningful while counter < WIDTH.
    always_comb begin
        idx    = IW'(WIDTH - 1) - IW'(counter);
        addend = mplier[idx] ? {{WIDTH{1'b0}}, mcand} : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out     <= '0;
            counter <= CW'(WIDTH);
            done    <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
        end else if (load) begin
            mcand   <= a;
            mplier  <= b;
            out     <= '0;
            counter <= '0;
            done    <= 1'b0;
        end else if (counter < CW'(WIDTH)) begin
            out     <= (out << 1) + addend;
            counter <= counter + 1'b1;
            done    <= (counter == CW'(WIDTH - 1));
        end
    end

    assign product = out;

endmodule

// File: tb/tb_unsigned_seq_mult_ls.sv
// Randomized and directed bench for unsigned_seq_mult_ls; the reference model
// predicts the partial product after k steps as a * (b >> (WIDTH-k)).
module tb_unsigned_seq_mult_ls;

    localparam int W = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            load = 1'b0;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic [2*W-1:0]  product;
    logic            done;

    int checks = 0;
    int errors = 0;

    unsigned_seq_mult_ls #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .load(load), .a(a), .b(b),
        .product(product), .done(done)
    );

    always #5 clk = ~clk;

    // Step past a rising edge so samples and new drives sit away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int ia, input int ib);
        a = W'(ia);
        b = W'(ib);
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    function automatic logic [2*W-1:0] partial(input int ia, input int ib, input int k);
        return (2*W)'(ia * (ib >> (W - k)));
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (product !== '0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: product=%0d done=%b, want product=0 done=0", i, product, done);
            end
            tick();
        end
    endtask

    task automatic test_max();
        do_load(63, 63);
        checks++;
        if (product !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL max_after_load: product=%0d done=%b, want 0/0", product, done);
        end
        for (int k = 1; k <= W; k++) begin
            tick();
            checks++;
            if (product !== partial(63, 63, k) || done !== (k == W)) begin
                errors++;
                $display("FAIL max_step%0d: product=%0d done=%b, want %0d/%b", k, product, done, partial(63, 63, k), (k == W));
            end
        end
        checks++;
        if (product !== 12'b111110000001) begin
            errors++;
            $display("FAIL max_final: product=%0d, want 3969", product);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (product !== 12'd3969 || done !== 1'b1) begin
                errors++;
                $display("FAIL max_hold[%0d]: product=%0d done=%b, want 3969/1", i, product, done);
            end
        end
    endtask

    task automatic test_operand_capture();
        do_load(5, 3);
        a = '0;
        b = '0;
        for (int k = 1; k <= W; k++) tick();
        checks++;
        if (product !== 12'd15 || done !== 1'b1) begin
            errors++;
            $display("FAIL capture_5x3: product=%0d done=%b, want 15/1", product, done);
        end
    endtask

    task automatic test_zero();
        int pa [2] = '{0, 45};
        int pb [2] = '{45, 0};
        for (int t = 0; t < 2; t++) begin
            do_load(pa[t], pb[t]);
            for (int k = 1; k <= W; k++) begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL zero_early_done[%0d] step%0d: done=%b, want 0", t, k, done);
                end
                tick();
            end
            checks++;
            if (product !== '0 || done !== 1'b1) begin
                errors++;
                $display("FAIL zero[%0d]: product=%0d done=%b, want 0/1", t, product, done);
            end
        end
    endtask

    task automatic test_abort_reset();
        do_load(63, 63);
        for (int k = 0; k < 3; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (product !== '0 || done !== 1'b0) begin
                errors++;
                $display("FAIL abort_rst[%0d]: product=%0d done=%b, want 0/0", i, product, done);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        do_load(63, 63);
        tick();
        tick();
        do_load(2, 7);
        for (int k = 1; k <= W; k++) begin
            tick();
            checks++;
            if (product !== partial(2, 7, k) || done !== (k == W)) begin
                errors++;
                $display("FAIL reload_step%0d: product=%0d done=%b, want %0d/%b", k, product, done, partial(2, 7, k), (k == W));
            end
        end
    endtask

    task automatic test_load_held();
        load = 1'b1;
        a = 6'd11; b = 6'd50; tick();
        a = 6'd33; b = 6'd21; tick();
        a = 6'd9;  b = 6'd13; tick();
        load = 1'b0;
        checks++;
        if (product !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL held_load: product=%0d done=%b, want 0/0", product, done);
        end
        for (int k = 1; k <= W; k++) tick();
        checks++;
        if (product !== 12'd117 || done !== 1'b1) begin
            errors++;
            $display("FAIL held_result: product=%0d done=%b, want 117/1", product, done);
        end
    endtask

    task automatic test_rst_load();
        rst = 1'b1;
        load = 1'b1;
        a = 6'd9;
        b = 6'd9;
        tick();
        rst = 1'b0;
        load = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            checks++;
            if (product !== '0 || done !== 1'b0) begin
                errors++;
                $display("FAIL rst_and_load[%0d]: product=%0d done=%b, want 0/0", i, product, done);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            int ra = $urandom_range(63, 0);
            int rb = $urandom_range(63, 0);
            do_load(ra, rb);
            for (int k = 1; k <= W; k++) begin
                tick();
                checks++;
                if (product !== partial(ra, rb, k) || done !== (k == W)) begin
                    errors++;
                    $display("FAIL rand %0dx%0d step%0d: product=%0d done=%b, want %0d/%b",
                             ra, rb, k, product, done, partial(ra, rb, k), (k == W));
                end
            end
            checks++;
            if (product !== (2*W)'(ra * rb)) begin
                errors++;
                $display("FAIL rand_final %0dx%0d: product=%0d, want %0d", ra, rb, product, ra * rb);
            end
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_max();
        test_operand_capture();
        test_zero();
        test_abort_reset();
        test_back_to_back();
        test_load_held();
        test_rst_load();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
